// File: rtl/icache_dm.sv
// icache_dm: direct-mapped instruction cache with multi-beat refill.
// Optional bulk invalidate port and logic enabled by ICACHE_FLUSH_EN.
module icache_dm #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int SETS       = 64,
   parameter int LINE_BEATS = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_kill,
   output logic              resp_valid,
   output logic [DATA_W-1:0] resp_data,
   output logic              acq_valid,
   input  logic              acq_ready,
   output logic [ADDR_W-1:0] acq_addr,
   input  logic              grant_valid,
   input  logic [DATA_W-1:0] grant_data
`ifdef ICACHE_FLUSH_EN
   ,
   input  logic              flush
`endif
);

   localparam int WOFF_W = $clog2(DATA_W / 8);
   localparam int BEAT_W = $clog2(LINE_BEATS);
   localparam int OFF_W  = WOFF_W + BEAT_W;
   localparam int IDX_W  = $clog2(SETS);
   localparam int TAG_W  = ADDR_W - OFF_W - IDX_W;
   localparam int WA_W   = ADDR_W - WOFF_W;
   localparam logic [BEAT_W-1:0] LAST = BEAT_W'(LINE_BEATS - 1);

   typedef enum logic [1:0] {
      READY,
      REQUEST,
      REFILL_WAIT,
      REFILL
   } state_t;

   state_t state_q, state_d;

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_mem  [SETS];
   logic [DATA_W-1:0] data_mem [SETS*LINE_BEATS];

   logic              s1_valid_q;
   logic [WA_W-1:0]   s1_wa_q;
   logic [BEAT_W-1:0] cnt_q;
   logic              killed_q;

   logic [IDX_W-1:0]  s1_idx;
   logic [TAG_W-1:0]  s1_tag;
   logic [BEAT_W-1:0] s1_beat;
   logic              s1_hit;
   logic              s1_miss;
   logic              accept;

   logic acq_fire;
   logic beat_we;
   logic install;
   logic drop_s1;
   logic kill_set;
   logic flush_req;
   logic do_flush;
   logic unused_lo;

   // byte-within-word address bits never matter for a word fetch
   generate
      if (WOFF_W > 0) begin : g_lo
         assign unused_lo = ^req_addr[(WOFF_W > 0 ? WOFF_W-1 : 0):0];
      end else begin : g_nolo
         assign unused_lo = 1'b0;
      end
   endgenerate

   assign s1_idx  = s1_wa_q[BEAT_W +: IDX_W];
   assign s1_tag  = s1_wa_q[WA_W-1 -: TAG_W];
   assign s1_beat = s1_wa_q[BEAT_W-1:0];

   assign s1_hit  = s1_valid_q && valid_q[s1_idx]
                    && (tag_mem[s1_idx] == s1_tag);
   assign s1_miss = s1_valid_q && !s1_hit;

`ifdef ICACHE_FLUSH_EN
   logic flush_pend_q;

   assign flush_req = flush || flush_pend_q;
   assign do_flush  = flush_req && (state_q == READY) && !s1_valid_q;

   // remember a flush until the pipe is idle enough to apply it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         flush_pend_q <= 1'b0;
      end else if (do_flush) begin
         flush_pend_q <= 1'b0;
      end else if (flush) begin
         flush_pend_q <= 1'b1;
      end
   end
`else
   assign flush_req = 1'b0;
   assign do_flush  = 1'b0;
`endif

   // new fetches wait out misses and drain ahead of a flush
   assign req_ready = (state_q == READY) && !s1_miss && !flush_req;
   assign accept    = req_valid && req_ready;

   assign resp_valid = (state_q == READY) && s1_hit;
   assign resp_data  = resp_valid ? data_mem[{s1_idx, s1_beat}] : '0;

   assign acq_valid = (state_q == REQUEST);
   assign acq_addr  = acq_valid ? {s1_wa_q[WA_W-1:BEAT_W], OFF_W'(0)}
                                : '0;

   // state register
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= READY;
      end else begin
         state_q <= state_d;
      end
   end

   // next state and refill control strobes
   always_comb begin
      state_d  = state_q;
      acq_fire = 1'b0;
      beat_we  = 1'b0;
      install  = 1'b0;
      drop_s1  = 1'b0;
      kill_set = 1'b0;
      unique case (state_q)
         READY: begin
            if (s1_miss) begin
               if (req_kill) begin
                  drop_s1 = 1'b1;
               end else begin
                  state_d = REQUEST;
               end
            end
         end
         REQUEST: begin
            if (acq_ready) begin
               acq_fire = 1'b1;
               kill_set = req_kill;
               state_d  = REFILL_WAIT;
            end else if (req_kill) begin
               drop_s1 = 1'b1;
               state_d = READY;
            end
         end
         REFILL_WAIT: begin
            kill_set = req_kill;
            if (grant_valid) begin
               beat_we = 1'b1;
               state_d = REFILL;
            end
         end
         REFILL: begin
            kill_set = req_kill;
            if (grant_valid) begin
               beat_we = 1'b1;
               if (cnt_q == LAST) begin
                  install = 1'b1;
                  state_d = READY;
               end
            end
         end
         default: state_d = READY;
      endcase
   end

   // s1 lookup register: holds the miss address until replay or kill
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_valid_q <= 1'b0;
         s1_wa_q    <= '0;
      end else if (accept) begin
         s1_valid_q <= 1'b1;
         s1_wa_q    <= req_addr[ADDR_W-1:WOFF_W];
      end else if (drop_s1) begin
         s1_valid_q <= 1'b0;
      end else if (install && (killed_q || req_kill)) begin
         s1_valid_q <= 1'b0;
      end else if ((state_q == READY) && !s1_miss) begin
         s1_valid_q <= 1'b0;
      end
   end

   // beat counter and refill kill marker
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q    <= '0;
         killed_q <= 1'b0;
      end else begin
         if (beat_we) begin
            cnt_q <= install ? '0 : cnt_q + 1'b1;
         end
         if (install) begin
            killed_q <= 1'b0;
         end else if (kill_set) begin
            killed_q <= 1'b1;
         end
      end
   end

   // valid bits: dropped at acquire so a half-filled line never hits
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         valid_q <= '0;
      end else if (do_flush) begin
         valid_q <= '0;
      end else begin
         if (acq_fire) begin
            valid_q[s1_idx] <= 1'b0;
         end
         if (install) begin
            valid_q[s1_idx] <= 1'b1;
         end
      end
   end

   // tag and data arrays, no reset
   always_ff @(posedge clk) begin
      if (rst_n && beat_we) begin
         data_mem[{s1_idx, cnt_q}] <= grant_data;
      end
      if (rst_n && install) begin
         tag_mem[s1_idx] <= s1_tag;
      end
   end

endmodule
